inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage sitting directly downstream of the program counter register.
- Takes the current PC (`pc_in`) and issues one word read per instruction to instruction memory over a req/ready + rvalid handshake.
- Holds the returned instruction in an output register for decode under a valid/ready handshake.
- Pulses `pc_advance` so the PC next-value mux steps only when an instruction retires from fetch. Handles branch redirect by killing in-flight or held fetches.

Parameters:
- PC_W, 14, PC width in bits (byte address).
- INST_W, 32, instruction width.
- NOP_INST, 32'h00000013, instruction emitted on a misaligned fetch (ADDI x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  PC_W  current PC from the program counter register.
- pc_advance  output  1  one-cycle pulse; the PC mux selects the sequential next PC on that edge.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  PC_W-2  word address, equal to `pc_in[PC_W-1:2]`.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  INST_W  read data.
- redirect  input  1  branch/jump taken; the PC loads its target on this edge.
- inst_valid  output  1  output register holds an instruction.
- inst_out  output  INST_W  instruction to decode.
- inst_pc  output  PC_W  PC of `inst_out`.
- inst_misalign  output  1  `inst_out` comes from a misaligned PC; accompanies `inst_valid`.
- dec_ready  input  1  decode accepts the instruction.

Behaviour:
- States: IDLE, REQ, WAIT, HOLD. The memory handles at most one outstanding request.
- Reset applies in any state, mid-transaction included. Next state is IDLE. `inst_valid`, `inst_misalign`, `pc_advance`, `imem_req` = 0; `inst_out` = NOP_INST; `inst_pc` = 0; kill flag = 0. An `imem_rvalid` arriving after reset, outside WAIT, is ignored.
- IDLE: outputs inactive; unconditionally go to REQ next cycle.
- REQ:
  - `imem_req = !redirect && pc_in[1:0]==0`; `imem_addr = pc_in[PC_W-1:2]` (combinational).
  - If redirect: stay in REQ; no request is issued this cycle.
  - Else if `pc_in[1:0]!=0`: no request. Load `inst_out`=NOP_INST, `inst_pc`=`pc_in`, `inst_misalign`=1, `inst_valid`=1; go to HOLD.
  - Else if `imem_ready`: latch `req_pc`=`pc_in`, clear kill; go to WAIT.
  - Else stay in REQ with `imem_req` held high.
- WAIT:
  - `imem_req`=0.
  - `redirect` sets the kill flag.
  - On `imem_rvalid`:
    - If kill (or redirect in the same cycle): discard data, clear kill, go to REQ.
    - Else load `inst_out`=`imem_rdata`, `inst_pc`=`req_pc`, `inst_misalign`=0, `inst_valid`=1; go to HOLD.
  - Latency is unbounded; there is no timeout.
- HOLD:
  - `inst_valid`=1 and `inst_out`/`inst_pc` stable until handshake.
  - If redirect: drop `inst_valid`, no `pc_advance`, go to REQ. Redirect wins over a simultaneous `dec_ready`.
  - Else if `dec_ready`: `pc_advance`=1 for exactly this cycle, `inst_valid`=0 next cycle, go to REQ.
- `pc_advance` asserts only in HOLD & `dec_ready` & !redirect; never two consecutive cycles.
- Throughput is at best one instruction per 3 cycles (REQ→WAIT→HOLD) with 1-cycle memory.
- `pc_in` must be stable between `pc_advance`/redirect events; fetch samples it in REQ only.
- No arithmetic on PC; `imem_addr` is a pure bit-slice. Wrap-around is the PC's concern.

Test Plan:
1. Reset release with `pc_in`=0x0000, memory `imem_ready`=1 and `rvalid` one cycle later with 0x00500093 → `imem_req` in cycle 2 (`imem_addr`=0); `inst_valid`=1, `inst_out`=0x00500093, `inst_pc`=0 in cycle 4. `dec_ready`=1 → `pc_advance` single pulse.
2. Backpressure: `dec_ready`=0 for 5 cycles in HOLD → `inst_valid`/`inst_out` stable, no `pc_advance`, no new `imem_req`. Raise `dec_ready` → exactly one `pc_advance`.
3. Memory stall: `imem_ready`=0 for 3 cycles with `pc_in`=0x0010 → `imem_req`=1, `imem_addr`=0x004 held all 4 cycles. Single acceptance, one response captured.
4. Redirect in WAIT: request at `pc_in`=0x0020, `redirect` pulse before `rvalid` → returned data discarded, `inst_valid` stays 0. Next request uses the new `pc_in` (e.g. 0x0100 → `imem_addr` 0x040).
5. Redirect in HOLD with `dec_ready`=1 the same cycle → `inst_valid` drops, no `pc_advance`, FSM re-enters REQ.
6. Misaligned `pc_in`=0x0006 → no `imem_req`; `inst_valid`=1, `inst_out`=0x00000013, `inst_misalign`=1, `inst_pc`=0x0006. Also assert reset during WAIT, then late `rvalid` → ignored, `inst_valid`=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Fetch stage sitting right after the program counter register. For each
// instruction it issues one word read to instruction memory (req/ready, then
// rvalid), holds the returned word in an output register for decode
// (valid/ready), and pulses pc_advance when that instruction retires so the
// PC steps to its sequential successor. A branch redirect kills any fetch that
// is in flight or being held.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   pc_in             current PC (byte address), sampled only in REQ
//   pc_advance        one-cycle pulse: PC takes its sequential next value
//   imem_req          read request to instruction memory
//   imem_addr         word address (pure bit-slice of pc_in)
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid       read data valid
//   imem_rdata        read data
//   redirect          branch/jump taken; PC loads its target on this edge
//   inst_valid        output register holds an instruction
//   inst_out          instruction to decode
//   inst_pc           PC of inst_out
//   inst_misalign     inst_out is a NOP standing in for a misaligned fetch
//   dec_ready         decode accepts the instruction
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int                PC_W     = 14,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_in,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [PC_W-3:0]   imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_misalign,
  input  logic              dec_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     req_pc_q, req_pc_d;
  logic                kill_q, kill_d;
  logic                inst_valid_q, inst_valid_d;
  logic [INST_W-1:0]   inst_out_q, inst_out_d;
  logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
  logic                inst_misalign_q, inst_misalign_d;

  logic                pc_misaligned;

  assign pc_misaligned = (pc_in[1:0] != 2'b00);

  // Memory-side outputs. The address is always driven; only the request is
  // qualified. Reset gates the request so nothing is issued in a reset cycle.
  assign imem_addr = pc_in[PC_W-1:2];
  assign imem_req  = !reset && (state_q == REQ) && !redirect && !pc_misaligned;

  // Retirement pulse: a redirect in the same cycle means the held instruction
  // is on the wrong path, so it wins over the decode handshake.
  assign pc_advance = !reset && (state_q == HOLD) && dec_ready && !redirect;

  assign inst_valid    = inst_valid_q;
  assign inst_out      = inst_out_q;
  assign inst_pc       = inst_pc_q;
  assign inst_misalign = inst_misalign_q;

  // Next-state logic for the fetch FSM and its output register.
  always_comb begin
    state_d         = state_q;
    req_pc_d        = req_pc_q;
    kill_d          = kill_q;
    inst_valid_d    = inst_valid_q;
    inst_out_d      = inst_out_q;
    inst_pc_d       = inst_pc_q;
    inst_misalign_d = inst_misalign_q;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end

      REQ: begin
        if (redirect) begin
          // PC is loading a new target this edge; retry with it next cycle.
          state_d = REQ;
        end else if (pc_misaligned) begin
          // Never touch memory for a misaligned PC; hand decode a NOP tagged
          // as misaligned so the exception can be raised downstream.
          inst_out_d      = NOP_INST;
          inst_pc_d       = pc_in;
          inst_misalign_d = 1'b1;
          inst_valid_d    = 1'b1;
          state_d         = HOLD;
        end else if (imem_ready) begin
          req_pc_d = pc_in;
          kill_d   = 1'b0;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            // Response belongs to a squashed fetch; drop it and refetch.
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_out_d      = imem_rdata;
            inst_pc_d       = req_pc_q;
            inst_misalign_d = 1'b0;
            inst_valid_d    = 1'b1;
            state_d         = HOLD;
          end
        end else if (redirect) begin
          // Memory still owes us a response; remember to discard it.
          kill_d = 1'b1;
        end
      end

      HOLD: begin
        if (redirect || dec_ready) begin
          inst_valid_d    = 1'b0;
          inst_misalign_d = 1'b0;
          state_d         = REQ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      req_pc_q        <= '0;
      kill_q          <= 1'b0;
      inst_valid_q    <= 1'b0;
      inst_out_q      <= NOP_INST;
      inst_pc_q       <= '0;
      inst_misalign_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_pc_q        <= req_pc_d;
      kill_q          <= kill_d;
      inst_valid_q    <= inst_valid_d;
      inst_out_q      <= inst_out_d;
      inst_pc_q       <= inst_pc_d;
      inst_misalign_q <= inst_misalign_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Directed bench for inst_fetch_unit. One linear sequence of cycles; in each
// cycle the inputs are driven just after the rising edge and the outputs are
// checked against hand-computed values before the next edge. A negedge
// monitor counts accepted memory requests and pc_advance pulses and checks
// that pc_advance never lasts two cycles.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int PC_W   = 14;
  localparam int INST_W = 32;

  logic              clk;
  logic              reset;
  logic [PC_W-1:0]   pc_in;
  logic              pc_advance;
  logic              imem_req;
  logic [PC_W-3:0]   imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              redirect;
  logic              inst_valid;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_misalign;
  logic              dec_ready;

  int checks   = 0;
  int failures = 0;
  int adv_count = 0;
  int acc_count = 0;
  logic adv_prev = 1'b0;

  inst_fetch_unit #(
    .PC_W    (PC_W),
    .INST_W  (INST_W),
    .NOP_INST(32'h00000013)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_advance   (pc_advance),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .inst_valid   (inst_valid),
    .inst_out     (inst_out),
    .inst_pc      (inst_pc),
    .inst_misalign(inst_misalign),
    .dec_ready    (dec_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Wait for the next rising edge, drive this cycle's inputs, let them settle.
  task automatic applyStimulus(input logic rst, input logic [PC_W-1:0] pc,
                               input logic ready, input logic rv,
                               input logic [INST_W-1:0] rdata,
                               input logic redir, input logic dready);
    @(posedge clk);
    #1;
    reset       = rst;
    pc_in       = pc;
    imem_ready  = ready;
    imem_rvalid = rv;
    imem_rdata  = rdata;
    redirect    = redir;
    dec_ready   = dready;
    #1;
  endtask

  // Bookkeeping sampled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (imem_req && imem_ready) acc_count++;
    if (pc_advance) adv_count++;
    if (pc_advance) begin
      checks++;
      assert (!adv_prev) else begin
        failures++;
        $error("[TB] FAIL pc_advance_consecutive observed=1 expected=0");
      end
    end
    adv_prev = pc_advance;
  end

  initial begin
    reset       = 1'b1;
    pc_in       = '0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    dec_ready   = 1'b0;

    // Reset state
    applyStimulus(1'b1, 14'h0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 14'h0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("rst_valid",    32'(inst_valid),    32'h0);
    checkOutput("rst_out",      inst_out,           32'h00000013);
    checkOutput("rst_pc",       32'(inst_pc),       32'h0);
    checkOutput("rst_misalign", 32'(inst_misalign), 32'h0);
    checkOutput("rst_req",      32'(imem_req),      32'h0);
    checkOutput("rst_adv",      32'(pc_advance),    32'h0);

    // Test 1: basic fetch at PC 0. Cycle 1 IDLE
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_c1_req", 32'(imem_req), 32'h0);
    // Cycle 2 REQ
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_c2_req",  32'(imem_req),  32'h1);
    checkOutput("t1_c2_addr", 32'(imem_addr), 32'h0);
    // Cycle 3 WAIT, data returns
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b1, 32'h00500093, 1'b0, 1'b0);
    checkOutput("t1_c3_req",   32'(imem_req),   32'h0);
    checkOutput("t1_c3_valid", 32'(inst_valid), 32'h0);
    // Cycle 4 HOLD, decode accepts
    applyStimulus(1'b0, 14'h0000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t1_c4_valid", 32'(inst_valid),    32'h1);
    checkOutput("t1_c4_out",   inst_out,           32'h00500093);
    checkOutput("t1_c4_pc",    32'(inst_pc),       32'h0);
    checkOutput("t1_c4_mis",   32'(inst_misalign), 32'h0);
    checkOutput("t1_c4_adv",   32'(pc_advance),    32'h1);
    // Cycle 5 REQ at the advanced PC
    applyStimulus(1'b0, 14'h0004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_c5_adv",   32'(pc_advance), 32'h0);
    checkOutput("t1_c5_valid", 32'(inst_valid), 32'h0);
    checkOutput("t1_c5_req",   32'(imem_req),   32'h1);
    checkOutput("t1_c5_addr",  32'(imem_addr),  32'h1);

    // Test 2: decode backpressure
    applyStimulus(1'b0, 14'h0004, 1'b1, 1'b1, 32'h00100113, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 14'h0004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("t2_hold_valid", 32'(inst_valid), 32'h1);
      checkOutput("t2_hold_out",   inst_out,        32'h00100113);
      checkOutput("t2_hold_pc",    32'(inst_pc),    32'h4);
      checkOutput("t2_hold_adv",   32'(pc_advance), 32'h0);
      checkOutput("t2_hold_req",   32'(imem_req),   32'h0);
    end
    applyStimulus(1'b0, 14'h0004, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t2_release_adv", 32'(pc_advance), 32'h1);

    // Test 3: memory stall at PC 0x10
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 14'h0010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("t3_stall_req",  32'(imem_req),  32'h1);
      checkOutput("t3_stall_addr", 32'(imem_addr), 32'h4);
      checkOutput("t3_stall_adv",  32'(pc_advance), 32'h0);
    end
    applyStimulus(1'b0, 14'h0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t3_accept_req",  32'(imem_req),  32'h1);
    checkOutput("t3_accept_addr", 32'(imem_addr), 32'h4);
    applyStimulus(1'b0, 14'h0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t3_wait_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 14'h0010, 1'b1, 1'b1, 32'hAAAA5555, 1'b0, 1'b0);
    checkOutput("t3_rv_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 14'h0010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t3_hold_valid", 32'(inst_valid), 32'h1);
    checkOutput("t3_hold_out",   inst_out,        32'hAAAA5555);
    checkOutput("t3_hold_pc",    32'(inst_pc),    32'h10);
    checkOutput("t3_hold_adv",   32'(pc_advance), 32'h1);

    // Test 4: redirect while waiting for memory
    applyStimulus(1'b0, 14'h0020, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t4_req",  32'(imem_req),  32'h1);
    checkOutput("t4_addr", 32'(imem_addr), 32'h8);
    applyStimulus(1'b0, 14'h0020, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t4_redir_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 14'h0100, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("t4_stale_valid", 32'(inst_valid), 32'h0);
    applyStimulus(1'b0, 14'h0100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t4_drop_valid", 32'(inst_valid), 32'h0);
    checkOutput("t4_new_req",    32'(imem_req),   32'h1);
    checkOutput("t4_new_addr",   32'(imem_addr),  32'h40);
    applyStimulus(1'b0, 14'h0100, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);

    // Test 5: redirect in HOLD beats a simultaneous dec_ready
    applyStimulus(1'b0, 14'h0100, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("t5_valid", 32'(inst_valid), 32'h1);
    checkOutput("t5_out",   inst_out,        32'h12345678);
    checkOutput("t5_pc",    32'(inst_pc),    32'h100);
    checkOutput("t5_adv",   32'(pc_advance), 32'h0);
    applyStimulus(1'b0, 14'h0200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t5_after_valid", 32'(inst_valid), 32'h0);
    checkOutput("t5_after_req",   32'(imem_req),   32'h1);
    checkOutput("t5_after_addr",  32'(imem_addr),  32'h80);
    // Redirect while still in REQ suppresses the request
    applyStimulus(1'b0, 14'h0200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("t5_req_redir", 32'(imem_req), 32'h0);

    // Test 6: misaligned PC produces a tagged NOP without touching memory
    applyStimulus(1'b0, 14'h0006, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_mis_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 14'h0006, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("t6_valid", 32'(inst_valid),    32'h1);
    checkOutput("t6_out",   inst_out,           32'h00000013);
    checkOutput("t6_mis",   32'(inst_misalign), 32'h1);
    checkOutput("t6_pc",    32'(inst_pc),       32'h6);
    checkOutput("t6_adv",   32'(pc_advance),    32'h1);
    applyStimulus(1'b0, 14'h0008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_next_mis",  32'(inst_misalign), 32'h0);
    checkOutput("t6_next_req",  32'(imem_req),      32'h1);
    checkOutput("t6_next_addr", 32'(imem_addr),     32'h2);
    // Reset while WAIT, then a late response
    applyStimulus(1'b1, 14'h0008, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_rst_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b0, 14'h0008, 1'b0, 1'b1, 32'h0BADBAD0, 1'b0, 1'b0);
    checkOutput("t6_late_valid", 32'(inst_valid), 32'h0);
    checkOutput("t6_late_out",   inst_out,        32'h00000013);
    checkOutput("t6_late_pc",    32'(inst_pc),    32'h0);
    applyStimulus(1'b0, 14'h0008, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    checkOutput("t6_req_valid", 32'(inst_valid), 32'h0);
    checkOutput("t6_req_req",   32'(imem_req),   32'h1);
    applyStimulus(1'b0, 14'h0008, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("t6_final_valid", 32'(inst_valid), 32'h0);
    checkOutput("t6_final_out",   inst_out,        32'h00000013);

    // Totals over the whole run
    @(posedge clk);
    #1;
    checkOutput("total_pc_advance", 32'(adv_count), 32'd4);
    checkOutput("total_accepted",   32'(acc_count), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
